regfile_rename_mp: RTL
======================

Name: regfile_rename_mp

Overview:
- Parametrised successor to the single-commit rename register file in the out-of-order core.
- Holds architectural values plus per-register ROB rename tag and busy bit.
- Supports N decoder read ports, M same-cycle ROB commit ports, and commit-to-read bypass.
- Adds a flush input for misprediction recovery that clears all rename state while keeping committed data.

Parameters:
- XLEN, 32, data width of each register.
- REG_NUM, 32, number of architectural registers; index 0 is hardwired zero.
- ROB_TAG_W, 4, width of ROB tag; tag 0 means "no producer".
- READ_PORTS, 2, number of decoder read ports.
- COMMIT_PORTS, 2, number of ROB commit ports; higher index is the younger commit.
- Localparam IDX_W = $clog2(REG_NUM).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- ena  in  1  global enable; low freezes rename and commit updates.
- flush  in  1  misprediction recovery: clear all busy bits and tags.
- rd_idx  in  READ_PORTS*IDX_W  packed read indices; port k occupies bits [k*IDX_W +: IDX_W].
- rd_value  out  READ_PORTS*XLEN  packed read data.
- rd_tag  out  READ_PORTS*ROB_TAG_W  packed current producer tags.
- rd_busy  out  READ_PORTS  per-port busy (value pending).
- occupy_ena  in  1  decoder renames a destination this cycle.
- occupy_reg  in  IDX_W  destination register.
- occupy_tag  in  ROB_TAG_W  ROB tag allocated to that destination.
- commit_valid  in  COMMIT_PORTS  per-port commit strobe.
- commit_reg  in  COMMIT_PORTS*IDX_W  packed committed destination.
- commit_tag  in  COMMIT_PORTS*ROB_TAG_W  packed ROB tag of committing entry.
- commit_value  in  COMMIT_PORTS*XLEN  packed committed value.

Behaviour:
- Reset (rst low, asynchronous): all data = 0, all tags = 0, all busy = 0. Reads therefore return value 0, tag 0, busy 0.
- Register 0:
  - Never written, renamed, or marked busy.
  - Commits and occupies targeting 0 are ignored.
  - Reads of 0 always return 0/0/0, with no bypass.
- Commit (sequential, ena=1, commit_valid[j]=1, commit_reg[j]=r≠0):
  - data[r] <= commit_value[j].
  - If commit_tag[j]==tag[r]: tag[r] <= 0, busy[r] <= 0.
  - A tag mismatch means a younger rename is outstanding: data is updated, rename state is kept.
- Multiple commits to the same r in one cycle:
  - Highest-index valid port's value wins the data write.
  - Busy/tag clears if any matching port's tag equals the current tag[r].
- Occupy (sequential, ena=1, occupy_ena=1, occupy_reg=r≠0): tag[r] <= occupy_tag, busy[r] <= 1. Occupy takes priority over a same-cycle commit clear on the same r; data is still written by the commit.
- Flush (sequential, independent of ena):
  - All tags <= 0, all busy <= 0.
  - Same-cycle commits with ena=1 still write data.
  - Same-cycle occupy is discarded; flush wins.
- ena=0: no data, tag, or busy changes except by flush. Reads remain live.
- Reads are combinational, zero latency, per port k, index r:
  - Base: rd_value=data[r], rd_tag=tag[r], rd_busy=busy[r].
  - Bypass: if ena=1 and some commit_valid[j] has commit_reg[j]==r≠0, then rd_value = commit_value of the highest such j.
  - If additionally that port's commit_tag==tag[r]: rd_busy=0 and rd_tag=0.
  - Same-cycle occupy is not reflected in reads (pre-occupy state). The decoder handles its own intra-cycle dependency.
- No internal FSM beyond the register state. Every read port is independent; identical indices on several ports return identical results.

Test Plan:
- Reset, then read r5 on both ports -> value 0, tag 0, busy 0. Assert rst low mid-run after writes -> all outputs 0 immediately, with no clock edge.
- Occupy r3 with tag 6; next cycle commit r3 tag 6 value 0xDEADBEEF -> same cycle: read r3 gives 0xDEADBEEF, busy 0 (bypass). After the edge: stored value 0xDEADBEEF, busy 0, tag 0.
- Occupy r3 tag 6, then occupy r3 tag 9, then commit r3 tag 6 value 0x11 -> data 0x11, busy 1, tag 9 retained.
- Same cycle: port0 commits r7 value 0xA, port1 commits r7 value 0xB -> data[r7]=0xB. Commit r0 value 0xFF -> r0 reads 0.
- Occupy r4 tag 2 and r8 tag 3 over two cycles, then flush with a concurrent occupy r9 tag 5 and commit r4 value 0x55 -> all busy 0 and all tags 0; r9 not busy; data[r4]=0x55.
- ena=0 with occupy r2 tag 1 and commit r2 value 0x77 -> no state change, no bypass (r2 reads old value). Flush still clears busy.

Source files
------------

// File: rtl/regfile_rename_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_rename_mp
// Purpose  : Architectural register file with per-register rename state
//            (ROB producer tag + busy bit). Provides READ_PORTS combinational
//            decoder read ports, COMMIT_PORTS same-cycle ROB commit ports with
//            commit-to-read bypass, a single rename (occupy) port and a flush
//            that drops all rename state while keeping committed data.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous reset, active low
//            ena          - global enable for rename/commit updates and bypass
//            flush        - clear every busy bit and tag (independent of ena)
//            rd_idx       - packed read indices, port k at [k*IDX_W +: IDX_W]
//            rd_value     - packed read data
//            rd_tag       - packed producer tags (0 = no producer)
//            rd_busy      - per-port value-pending flag
//            occupy_ena   - rename a destination this cycle
//            occupy_reg   - destination register being renamed
//            occupy_tag   - ROB tag allocated to that destination
//            commit_valid - per-port commit strobe (higher index = younger)
//            commit_reg   - packed committed destination registers
//            commit_tag   - packed ROB tags of committing entries
//            commit_value - packed committed values
// Revision : 1.0 - initial release
// ============================================================================
module regfile_rename_mp #(
  parameter int XLEN         = 32,
  parameter int REG_NUM      = 32,
  parameter int ROB_TAG_W    = 4,
  parameter int READ_PORTS   = 2,
  parameter int COMMIT_PORTS = 2,
  localparam int IDX_W       = $clog2(REG_NUM)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ena,
  input  logic                              flush,
  input  logic [READ_PORTS*IDX_W-1:0]       rd_idx,
  output logic [READ_PORTS*XLEN-1:0]        rd_value,
  output logic [READ_PORTS*ROB_TAG_W-1:0]   rd_tag,
  output logic [READ_PORTS-1:0]             rd_busy,
  input  logic                              occupy_ena,
  input  logic [IDX_W-1:0]                  occupy_reg,
  input  logic [ROB_TAG_W-1:0]              occupy_tag,
  input  logic [COMMIT_PORTS-1:0]           commit_valid,
  input  logic [COMMIT_PORTS*IDX_W-1:0]     commit_reg,
  input  logic [COMMIT_PORTS*ROB_TAG_W-1:0] commit_tag,
  input  logic [COMMIT_PORTS*XLEN-1:0]      commit_value
);

  logic [XLEN-1:0]      r_data [REG_NUM];
  logic [ROB_TAG_W-1:0] r_tag  [REG_NUM];
  logic [REG_NUM-1:0]   r_busy;

  // Per-register commit decode: write strobe, winning value, rename clear.
  logic [REG_NUM-1:0]   w_cwr;
  logic [REG_NUM-1:0]   w_cclr;
  logic [REG_NUM-1:0]   w_occ;
  logic [XLEN-1:0]      w_cval [REG_NUM];

  always_comb begin
    w_cwr  = '0;
    w_cclr = '0;
    w_occ  = '0;
    for (int r = 0; r < REG_NUM; r++) begin
      w_cval[r] = '0;
      if (r != 0) begin
        w_occ[r] = ena && occupy_ena && (occupy_reg == IDX_W'(r));
        // Ascending scan: the youngest (highest) valid port's value wins,
        // while the clear is an OR over every matching port.
        for (int j = 0; j < COMMIT_PORTS; j++) begin
          if (ena && commit_valid[j] && (commit_reg[j*IDX_W +: IDX_W] == IDX_W'(r))) begin
            w_cwr[r]  = 1'b1;
            w_cval[r] = commit_value[j*XLEN +: XLEN];
            if (commit_tag[j*ROB_TAG_W +: ROB_TAG_W] == r_tag[r]) begin
              w_cclr[r] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Register 0 is only ever touched by reset, so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        r_data[r] <= '0;
        r_tag[r]  <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (w_cwr[r]) begin
          r_data[r] <= w_cval[r];
        end
        // Flush beats occupy, occupy beats a commit clear.
        if (flush) begin
          r_tag[r]  <= '0;
          r_busy[r] <= 1'b0;
        end else if (w_occ[r]) begin
          r_tag[r]  <= occupy_tag;
          r_busy[r] <= 1'b1;
        end else if (w_cclr[r]) begin
          r_tag[r]  <= '0;
          r_busy[r] <= 1'b0;
        end
      end
    end
  end

  // Read ports: stored state plus commit bypass; same-cycle occupy is not seen.
  logic [IDX_W-1:0] w_ridx  [READ_PORTS];
  logic [READ_PORTS-1:0] w_hit;
  logic [READ_PORTS-1:0] w_match;

  always_comb begin
    rd_value = '0;
    rd_tag   = '0;
    rd_busy  = '0;
    w_hit    = '0;
    w_match  = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      w_ridx[k] = rd_idx[k*IDX_W +: IDX_W];
      if ((w_ridx[k] != '0) && (32'(w_ridx[k]) < REG_NUM)) begin
        rd_value[k*XLEN +: XLEN]           = r_data[w_ridx[k]];
        rd_tag[k*ROB_TAG_W +: ROB_TAG_W]   = r_tag[w_ridx[k]];
        rd_busy[k]                         = r_busy[w_ridx[k]];
        // The tag match follows the same youngest port that supplies data.
        for (int j = 0; j < COMMIT_PORTS; j++) begin
          if (ena && commit_valid[j] && (commit_reg[j*IDX_W +: IDX_W] == w_ridx[k])) begin
            w_hit[k]                 = 1'b1;
            rd_value[k*XLEN +: XLEN] = commit_value[j*XLEN +: XLEN];
            w_match[k]               = (commit_tag[j*ROB_TAG_W +: ROB_TAG_W] == r_tag[w_ridx[k]]);
          end
        end
        if (w_hit[k] && w_match[k]) begin
          rd_tag[k*ROB_TAG_W +: ROB_TAG_W] = '0;
          rd_busy[k]                       = 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire
